// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the NOP encoding, the IF/ID buffer state
// encoding and the default-width fetch entry layout.
package pipe_pkg;

    // Canonical RV32I NOP (addi x0, x0, 0) used to fill empty slots.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Default field widths of a fetch entry.
    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    // Occupancy-encoded buffer states.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    // One fetched instruction together with its PC.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

endpackage

// File: rtl/if_id_skid_buffer.sv
// Two-entry in-order skid buffer between fetch and decode. in_ready is a
// pure decode of the state register, so fetch never sees a combinational
// path from decode's out_ready. A flush empties the buffer outright.
import pipe_pkg::*;

module if_id_skid_buffer #(
    parameter int AddrSize  = 32,
    parameter int Inst_Size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [Inst_Size-1:0] in_inst,
    input  logic [AddrSize-1:0]  in_pc,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [Inst_Size-1:0] out_inst,
    output logic [AddrSize-1:0]  out_pc,
    input  logic                 out_ready,
    output logic [1:0]           occupancy
);

    // Entry layout of the package entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [Inst_Size-1:0] inst;
        logic [AddrSize-1:0]  pc;
    } slot_t;

    localparam logic [Inst_Size-1:0] NOP      = Inst_Size'(NOP_INST);
    localparam slot_t                NOP_SLOT = '{inst: NOP, pc: {AddrSize{1'b0}}};

    buf_state_e state_r;
    buf_state_e state_next;
    slot_t      head_r;
    slot_t      head_next;
    slot_t      tail_r;
    slot_t      tail_next;
    slot_t      in_slot;
    logic       push;
    logic       pop;

    assign in_slot   = '{inst: in_inst, pc: in_pc};
    assign in_ready  = (state_r != ST_FULL);
    assign out_valid = (state_r != ST_EMPTY);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // The head slot is kept at NOP/0 whenever the buffer is empty, so the
    // data outputs come straight from a register.
    assign out_inst  = head_r.inst;
    assign out_pc    = head_r.pc;

    // State and storage registers; reset and flush both leave NOP/0 slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
            head_r  <= NOP_SLOT;
            tail_r  <= NOP_SLOT;
        end else begin
            state_r <= state_next;
            head_r  <= head_next;
            tail_r  <= tail_next;
        end
    end

    // Next-state and slot update: flush wins, otherwise push/pop per state.
    always_comb begin
        state_next = state_r;
        head_next  = head_r;
        tail_next  = tail_r;
        if (flush) begin
            state_next = ST_EMPTY;
            head_next  = NOP_SLOT;
            tail_next  = NOP_SLOT;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push) begin
                        state_next = ST_ONE;
                        head_next  = in_slot;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        // Head leaves while the new entry takes its place.
                        head_next = in_slot;
                    end else if (push) begin
                        state_next = ST_FULL;
                        tail_next  = in_slot;
                    end else if (pop) begin
                        state_next = ST_EMPTY;
                        head_next  = NOP_SLOT;
                    end else begin
                        state_next = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_next = ST_ONE;
                        head_next  = tail_r;
                        tail_next  = NOP_SLOT;
                    end else begin
                        state_next = ST_FULL;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    head_next  = NOP_SLOT;
                    tail_next  = NOP_SLOT;
                end
            endcase
        end
    end

    // Occupancy count decoded from the state register.
    always_comb begin
        occupancy = 2'd0;
        case (state_r)
            ST_EMPTY: occupancy = 2'd0;
            ST_ONE:   occupancy = 2'd1;
            ST_FULL:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

endmodule

// File: doc/if_id_skid_buffer.md
IF_ID_SKID_BUFFER -- requirements
Module: if_id_skid_buffer

Interface
REQ-001 SHALL have parameter AddrSize, default 32, width of the PC field.
REQ-002 SHALL have parameter Inst_Size, default 32, width of the instruction field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  fetch stage presents a valid instruction.
REQ-006 SHALL have port in_inst  input  Inst_Size  fetched instruction word.
REQ-007 SHALL have port in_pc  input  AddrSize  word address of in_inst.
REQ-008 SHALL have port in_ready  output  1  buffer accepts an entry this cycle; drives fetch-stage PC stall.
REQ-009 SHALL have port flush  input  1  redirect (taken branch/jump); discard all buffered entries.
REQ-010 SHALL have port out_valid  output  1  head entry valid toward decode.
REQ-011 SHALL have port out_inst  output  Inst_Size  head instruction.
REQ-012 SHALL have port out_pc  output  AddrSize  head PC.
REQ-013 SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-014 SHALL have port occupancy  output  2  number of valid entries (0..2).

Function
REQ-015 SHALL implement a 2-entry in-order FIFO with states EMPTY, ONE, FULL.
REQ-016 SHALL define push = in_valid & in_ready & ~flush and pop = out_valid & out_ready & ~flush.
REQ-017 SHALL drive in_ready = (state != FULL), decoded from state only, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = (state != EMPTY) and occupancy = 0/1/2 for EMPTY/ONE/FULL.
REQ-019 SHALL transition EMPTY->ONE on push; otherwise hold EMPTY.
REQ-020 SHALL transition ONE->FULL on push & ~pop, ONE->EMPTY on pop & ~push, and hold ONE on push & pop (the new entry becomes head).
REQ-021 SHALL transition FULL->ONE on pop, moving the tail to the head; otherwise hold FULL.
REQ-022 SHALL give latency of one cycle: an entry pushed at edge N is visible on out_* after edge N.
REQ-023 SHALL hold out_inst and out_pc stable while out_valid & ~out_ready.
REQ-024 SHALL drive out_inst = NOP (32'h00000013) and out_pc = 0 when EMPTY.
REQ-025 SHALL make flush dominant: next state EMPTY regardless of in_valid, out_ready or current state; no push or pop occurs that cycle.
REQ-026 SHALL ignore in_inst/in_pc when in_valid = 0, and ignore out_ready when out_valid = 0.
REQ-027 SHALL never drop, duplicate or reorder entries absent flush.

Reset
REQ-028 SHALL, on reset assertion, asynchronously force state EMPTY, both entries' data to NOP/0, and outputs out_valid=0, in_ready=1, occupancy=0, out_inst=NOP, out_pc=0.
REQ-029 SHALL discard in-flight entries on reset asserted mid-operation and accept a push on the first edge after deassertion.

Structure
REQ-030 SHALL take from shared package pipe_pkg: NOP instruction constant, the buffer state enum, and the entry struct {inst, pc}.
REQ-031 SHALL be a single module with storage and state machine inline; no sub-module is required.

Verification
REQ-032 SHALL cover reset: assert reset mid-FULL -> out_valid=0, in_ready=1, occupancy=0, out_inst=32'h00000013 immediately, without waiting for a clock edge.
REQ-033 SHALL cover streaming: push pc=0..7 with out_ready=1 continuously -> out_pc 0..7 in order, one per cycle after a 1-cycle latency, occupancy stays 1.
REQ-034 SHALL cover backpressure: out_ready=0 then push pc=4 and pc=5 -> occupancy=2, in_ready=0, out_pc held at 4; then out_ready=1 -> out_pc 5 next cycle, then EMPTY.
REQ-035 SHALL cover simultaneous push/pop in ONE: head pc=8, push pc=9 with out_ready=1 -> occupancy stays 1, out_pc=9 next cycle.
REQ-036 SHALL cover flush priority: FULL (pc=2,3), flush=1 with in_valid=1 (pc=10) and out_ready=1 -> EMPTY next cycle, pc=10 not captured, out_inst=NOP.
REQ-037 SHALL cover an in_ready-gated push: in_valid=1 while FULL and out_ready=0 -> no state change, data unchanged, in_valid value discarded.
